execute_cc_pipe: RTL and testbench
==================================

# execute_cc_pipe

Holds the Y86-64 condition-code register and the execute-to-memory pipeline register. It sits directly downstream of the execute-stage ALU result/flag multiplexer, which supplies the result and flags. It latches the selected ALU result and flags, and evaluates the branch/cmov condition `e_cnd` against the current condition codes. It registers everything the memory stage consumes, and honours stall/bubble control from the pipeline controller.

## Interface
Parameters:
- `W`, 64: datapath width of `valE`/`valA`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `E_icode`  in  4  instruction code in execute.
- `E_ifun`  in  4  function code in execute.
- `E_stat`  in  4  status code in execute.
- `E_valA`  in  W  operand A passthrough.
- `E_dstE`  in  4  destination for `valE`.
- `E_dstM`  in  4  destination for `valM`.
- `e_valE`  in  W  selected ALU result from the mux.
- `e_flags`  in  3  ALU flags `{ZF,SF,OF}` from the mux.
- `M_stall`  in  1  hold the M register.
- `M_bubble`  in  1  load a bubble into the M register.
- `m_stat`  in  4  memory-stage status (used only with `EXC_CC_GUARD_EN`).
- `W_stat`  in  4  writeback-stage status (used only with `EXC_CC_GUARD_EN`).
- `cc`  out  3  current `{ZF,SF,OF}`.
- `e_cnd`  out  1  combinational condition result.
- `e_dstE`  out  4  combinational `dstE` after cmov squash, for forwarding.
- `M_stat`, `M_icode`  out  4 each  registered to the memory stage.
- `M_Cnd`  out  1  registered condition result.
- `M_valE`, `M_valA`  out  W each  registered values.
- `M_dstE`, `M_dstM`  out  4 each  registered destinations.

## Operation
- **Condition evaluation** on `cc` (not `e_flags`), using `E_ifun`:
  - 0 → 1
  - 1 (le) → `(SF^OF)|ZF`
  - 2 (l) → `SF^OF`
  - 3 (e) → `ZF`
  - 4 (ne) → `~ZF`
  - 5 (ge) → `~(SF^OF)`
  - 6 (g) → `~(SF^OF)&~ZF`
  - 7–15 → 0
- **cmov squash:** `e_dstE = RNONE (4'hF)` when `E_icode==IRRMOVQ` and `e_cnd==0`; otherwise `e_dstE = E_dstE`.
- **CC update enable:** `set_cc = (E_icode==IOPQ) & ~M_stall`. When `set_cc` is high, `cc <= e_flags` at the clock edge. Otherwise `cc` holds.
- **M register priority:** `M_stall` > `M_bubble` > normal load.
  - Stall: all `M_*` hold.
  - Bubble: `M_icode=INOP`, `M_stat=SBUB`, `M_Cnd=0`, `M_valE=0`, `M_valA=0`, `M_dstE=M_dstM=RNONE`.
  - Normal: `M_icode<=E_icode`, `M_stat<=E_stat`, `M_Cnd<=e_cnd`, `M_valE<=e_valE`, `M_valA<=E_valA`, `M_dstE<=e_dstE`, `M_dstM<=E_dstM`.
- No arithmetic in this block. Values pass through at full width `W`, with no truncation.

## Timing
- **Reset values:** `cc=3'b100` (ZF=1), and the M register in its bubble values. Reset is asserted asynchronously and released synchronously to `clk` by the reset source.
- **Latency:** `e_cnd`/`e_dstE` are zero-cycle combinational. `M_*` outputs are 1 cycle. A `cc` update is visible to `e_cnd` in the cycle after the OPq is in execute, so an OPq immediately followed by jXX/cmovXX uses the new flags.
- **Simultaneous `M_stall` and `M_bubble`:** stall wins; no state changes, including `cc`.
- **Reset mid-operation:** all state returns immediately to reset values. Pending instructions are discarded.

## Configuration
- `EXC_CC_GUARD_EN` defined: `set_cc` is additionally gated by `m_stat ∉ {SADR,SINS,SHLT}` and `W_stat ∉ {SADR,SINS,SHLT}`. An OPq that follows an excepting instruction therefore leaves `cc` unchanged.
- `EXC_CC_GUARD_EN` undefined: the `m_stat`/`W_stat` ports remain but are ignored, and `set_cc` follows the base rule.

## Structure
- **Shared package `y86_pkg`:**
  - icode constants: `INOP=1`, `IRRMOVQ=2`, `IOPQ=6`, `IJXX=7`.
  - stat codes: `SBUB=0`, `SAOK=1`, `SADR=2`, `SINS=3`, `SHLT=4`.
  - `RNONE=4'hF`.
  - CC bit indices `ZF=2`, `SF=1`, `OF=0`.
- **Sub-module `cond_eval`:** combinational; `cc` and `ifun` in, `cnd` out. It is reused by any later branch-resolution logic.

## Test plan
- **Reset:** assert `rst` mid-cycle → `cc=3'b100`, `M_icode=1`, `M_stat=0`, `M_dstE=M_dstM=4'hF` without waiting for a clock edge.
- **OPq then jXX:** `E_icode=6` with `e_flags=3'b010` → next cycle, jl (`E_ifun=2`) gives `e_cnd=1`, and `M_Cnd=1` one cycle later.
- **cmovne squash:** `cc=3'b100`, `E_icode=2`, `E_ifun=4`, `E_dstE=3` → `e_dstE=4'hF`, and `M_dstE=4'hF` after the edge.
- **Stall and bubble:** assert `M_stall` and `M_bubble` together with `E_icode=6` and new flags → `M_*` and `cc` unchanged. Bubble alone → `M_icode=1`, `M_valE=0`.
- **Exception guard (with `EXC_CC_GUARD_EN`):** `W_stat=3`, `E_icode=6`, `e_flags=3'b001` → `cc` holds its prior value. Without the macro → `cc=3'b001`.
- **Full-width passthrough:** `e_valE=64'hFFFF_FFFF_FFFF_FFFF` and `E_valA=64'h8000_0000_0000_0001` → identical `M_valE`/`M_valA` after one clock.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register ids and
// condition-code bit positions used by the execute/memory pipeline logic.
package y86_pkg;

    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;

    localparam logic [3:0] SBUB = 4'd0;
    localparam logic [3:0] SAOK = 4'd1;
    localparam logic [3:0] SADR = 4'd2;
    localparam logic [3:0] SINS = 4'd3;
    localparam logic [3:0] SHLT = 4'd4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int ZF = 2;
    localparam int SF = 1;
    localparam int OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    // True for the status codes that stop the machine.
    function automatic logic stat_is_exc(input logic [3:0] s);
        return (s == SADR) || (s == SINS) || (s == SHLT);
    endfunction

endpackage

// File: rtl/execute_cc_pipe_if.sv
// Bundle of execute-stage inputs and memory-stage outputs around the CC/M register.
// master: upstream execute logic and controller; slave: execute_cc_pipe.
interface execute_cc_pipe_if #(
    parameter int W = 64
);
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [3:0]   E_stat;
    logic [W-1:0] E_valA;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic [W-1:0] e_valE;
    logic [2:0]   e_flags;
    logic         M_stall;
    logic         M_bubble;
    logic [3:0]   m_stat;
    logic [3:0]   W_stat;

    logic [2:0]   cc;
    logic         e_cnd;
    logic [3:0]   e_dstE;
    logic [3:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_Cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    modport master (
        output E_icode, E_ifun, E_stat, E_valA, E_dstE, E_dstM,
               e_valE, e_flags, M_stall, M_bubble, m_stat, W_stat,
        input  cc, e_cnd, e_dstE, M_stat, M_icode, M_Cnd,
               M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_icode, E_ifun, E_stat, E_valA, E_dstE, E_dstM,
               e_valE, e_flags, M_stall, M_bubble, m_stat, W_stat,
        output cc, e_cnd, e_dstE, M_stat, M_icode, M_Cnd,
               M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/cond_eval.sv
// Y86-64 jXX/cmovXX condition evaluation from {ZF,SF,OF} and the function code.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);
    logic w_lt;

    assign w_lt = cc[SF] ^ cc[OF];

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = w_lt | cc[ZF];
            4'd2:    cnd = w_lt;
            4'd3:    cnd = cc[ZF];
            4'd4:    cnd = ~cc[ZF];
            4'd5:    cnd = ~w_lt;
            4'd6:    cnd = ~w_lt & ~cc[ZF];
            default: cnd = 1'b0;
        endcase
    end
endmodule

// File: rtl/execute_cc_pipe.sv
// Condition-code register plus execute-to-memory pipeline register for Y86-64.
// Optional macro EXC_CC_GUARD_EN blocks CC updates while m/W hold an exception.
module execute_cc_pipe
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input logic              clk,
    input logic              rst,
    execute_cc_pipe_if.slave bus
);
    logic [2:0]   r_cc;
    logic         w_cnd;
    logic         w_set_cc;
    logic [3:0]   w_dstE;

    logic [3:0]   r_icode_p1;
    logic [3:0]   r_stat_p1;
    logic         r_cnd_p1;
    logic [W-1:0] r_valE_p1;
    logic [W-1:0] r_valA_p1;
    logic [3:0]   r_dstE_p1;
    logic [3:0]   r_dstM_p1;

    cond_eval u_cond_eval (
        .cc   (r_cc),
        .ifun (bus.E_ifun),
        .cnd  (w_cnd)
    );

    // A cmov whose condition fails must not write or forward its destination.
    assign w_dstE = ((bus.E_icode == IRRMOVQ) && !w_cnd) ? RNONE : bus.E_dstE;

`ifdef EXC_CC_GUARD_EN
    assign w_set_cc = (bus.E_icode == IOPQ) & ~bus.M_stall
                    & ~stat_is_exc(bus.m_stat) & ~stat_is_exc(bus.W_stat);
`else
    logic w_unused_stat;
    assign w_unused_stat = ^{bus.m_stat, bus.W_stat};
    assign w_set_cc      = (bus.E_icode == IOPQ) & ~bus.M_stall;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (w_set_cc) begin
            r_cc <= bus.e_flags;
        end
    end

    // ---- execute -> memory stage boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_icode_p1 <= INOP;
            r_stat_p1  <= SBUB;
            r_cnd_p1   <= 1'b0;
            r_valE_p1  <= '0;
            r_valA_p1  <= '0;
            r_dstE_p1  <= RNONE;
            r_dstM_p1  <= RNONE;
        end else if (bus.M_stall) begin
            r_icode_p1 <= r_icode_p1;
        end else if (bus.M_bubble) begin
            r_icode_p1 <= INOP;
            r_stat_p1  <= SBUB;
            r_cnd_p1   <= 1'b0;
            r_valE_p1  <= '0;
            r_valA_p1  <= '0;
            r_dstE_p1  <= RNONE;
            r_dstM_p1  <= RNONE;
        end else begin
            r_icode_p1 <= bus.E_icode;
            r_stat_p1  <= bus.E_stat;
            r_cnd_p1   <= w_cnd;
            r_valE_p1  <= bus.e_valE;
            r_valA_p1  <= bus.E_valA;
            r_dstE_p1  <= w_dstE;
            r_dstM_p1  <= bus.E_dstM;
        end
    end

    assign bus.cc      = r_cc;
    assign bus.e_cnd   = w_cnd;
    assign bus.e_dstE  = w_dstE;
    assign bus.M_icode = r_icode_p1;
    assign bus.M_stat  = r_stat_p1;
    assign bus.M_Cnd   = r_cnd_p1;
    assign bus.M_valE  = r_valE_p1;
    assign bus.M_valA  = r_valA_p1;
    assign bus.M_dstE  = r_dstE_p1;
    assign bus.M_dstM  = r_dstM_p1;
endmodule

// File: tb/tb_execute_cc_pipe.sv
// Directed bench for execute_cc_pipe: condition codes, cmov squash, M register
// stall/bubble priority, exception guard and asynchronous reset.
module tb_execute_cc_pipe;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    execute_cc_pipe_if #(.W(64)) bus ();

    execute_cc_pipe #(.W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] tbl;
        logic [2:0]  exp_guard_cc;
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.E_icode  = 4'd1;
        bus.E_ifun   = 4'd0;
        bus.E_stat   = 4'd1;
        bus.E_valA   = '0;
        bus.E_dstE   = 4'hF;
        bus.E_dstM   = 4'hF;
        bus.e_valE   = '0;
        bus.e_flags  = 3'b000;
        bus.M_stall  = 1'b0;
        bus.M_bubble = 1'b0;
        bus.m_stat   = 4'd1;
        bus.W_stat   = 4'd1;
        step();
        step();
        rst = 1'b0;

        chk("rst_cc", 64'(bus.cc), 64'h4);
        chk("rst_icode", 64'(bus.M_icode), 64'h1);
        chk("rst_stat", 64'(bus.M_stat), 64'h0);
        chk("rst_dstE", 64'(bus.M_dstE), 64'hF);

        // cmovne with ZF=1 is squashed
        bus.E_icode = 4'd2; bus.E_ifun = 4'd4; bus.E_dstE = 4'd3; bus.E_dstM = 4'hF;
        #1;
        chk("cmovne_cnd", 64'(bus.e_cnd), 64'h0);
        chk("cmovne_dstE", 64'(bus.e_dstE), 64'hF);
        step();
        chk("cmovne_M_dstE", 64'(bus.M_dstE), 64'hF);
        chk("cmovne_M_icode", 64'(bus.M_icode), 64'h2);

        // cmove with ZF=1 keeps its destination
        bus.E_ifun = 4'd3;
        #1;
        chk("cmove_dstE", 64'(bus.e_dstE), 64'h3);
        step();
        chk("cmove_M_Cnd", 64'(bus.M_Cnd), 64'h1);

        // OPq sets SF, then jl sees the new flags
        bus.E_icode = 4'd6; bus.E_ifun = 4'd0; bus.e_flags = 3'b010;
        bus.e_valE = 64'd5; bus.E_dstE = 4'd2;
        #1;
        chk("opq_cc_before", 64'(bus.cc), 64'h4);
        chk("opq_dstE", 64'(bus.e_dstE), 64'h2);
        step();
        chk("opq_cc_after", 64'(bus.cc), 64'h2);
        chk("opq_M_valE", bus.M_valE, 64'd5);
        bus.E_icode = 4'd7; bus.E_ifun = 4'd2; bus.E_dstE = 4'hF;
        #1;
        chk("jl_cnd", 64'(bus.e_cnd), 64'h1);
        step();
        chk("jl_M_Cnd", 64'(bus.M_Cnd), 64'h1);
        chk("jl_M_icode", 64'(bus.M_icode), 64'h7);

        // all function codes against cc={ZF=0,SF=1,OF=0}: 0,le,l,ne true
        tbl = 16'h0017;
        for (int i = 0; i < 16; i++) begin
            bus.E_ifun = 4'(i);
            #1;
            chk($sformatf("cond_ifun%0d", i), 64'(bus.e_cnd), 64'(tbl[i]));
        end

        // full-width passthrough
        bus.E_icode = 4'd2; bus.E_ifun = 4'd0; bus.E_dstE = 4'd1; bus.E_dstM = 4'd5;
        bus.e_valE = 64'hFFFF_FFFF_FFFF_FFFF; bus.E_valA = 64'h8000_0000_0000_0001;
        step();
        chk("wide_valE", bus.M_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wide_valA", bus.M_valA, 64'h8000_0000_0000_0001);
        chk("wide_dstM", 64'(bus.M_dstM), 64'h5);

        // stall and bubble together: nothing moves, not even cc
        bus.M_stall = 1'b1; bus.M_bubble = 1'b1;
        bus.E_icode = 4'd6; bus.e_flags = 3'b001; bus.e_valE = 64'h123; bus.E_valA = 64'h456;
        step();
        chk("stall_icode", 64'(bus.M_icode), 64'h2);
        chk("stall_valE", bus.M_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("stall_valA", bus.M_valA, 64'h8000_0000_0000_0001);
        chk("stall_cc", 64'(bus.cc), 64'h2);

        // bubble alone: M cleared, OPq in execute still updates cc
        bus.M_stall = 1'b0;
        step();
        chk("bub_icode", 64'(bus.M_icode), 64'h1);
        chk("bub_stat", 64'(bus.M_stat), 64'h0);
        chk("bub_valE", bus.M_valE, 64'h0);
        chk("bub_dstE", 64'(bus.M_dstE), 64'hF);
        chk("bub_cc", 64'(bus.cc), 64'h1);

        // OPq behind an excepting instruction in writeback
        bus.M_bubble = 1'b0; bus.W_stat = 4'd3; bus.e_flags = 3'b110;
`ifdef EXC_CC_GUARD_EN
        exp_guard_cc = 3'b001;
`else
        exp_guard_cc = 3'b110;
`endif
        step();
        chk("guard_cc", 64'(bus.cc), 64'(exp_guard_cc));
        bus.W_stat = 4'd1;

        // normal load with status, then reset mid-cycle
        bus.E_stat = 4'd1; bus.e_flags = 3'b011; bus.E_dstE = 4'd7; bus.E_dstM = 4'd9;
        bus.e_valE = 64'hDEAD_BEEF;
        step();
        chk("load_stat", 64'(bus.M_stat), 64'h1);
        chk("load_icode", 64'(bus.M_icode), 64'h6);
        chk("load_cc", 64'(bus.cc), 64'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cc", 64'(bus.cc), 64'h4);
        chk("arst_icode", 64'(bus.M_icode), 64'h1);
        chk("arst_stat", 64'(bus.M_stat), 64'h0);
        chk("arst_dstE", 64'(bus.M_dstE), 64'hF);
        chk("arst_dstM", 64'(bus.M_dstM), 64'hF);
        chk("arst_valE", bus.M_valE, 64'h0);
        step();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
